// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset PC, bubble word,
// next-PC selector encodings and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// D-stage redirect decision and target address for branch, j/jal and jr.
// Validity and stall qualification are applied by the caller.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] D_Instr,
    input  logic [31:0] D_PC,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] D_rs_val,
    output logic        redirect,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic        unused_opcode;

    assign pc_plus4      = D_PC + 32'd4;
    assign br_offset     = {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00};
    assign unused_opcode = ^D_Instr[31:26];

    always_comb begin
        redirect = 1'b0;
        target   = pc_plus4;
        case (npc_sel)
            NPC_BR: begin
                redirect = br_taken;
                target   = pc_plus4 + br_offset;
            end
            NPC_J: begin
                redirect = 1'b1;
                target   = {pc_plus4[31:28], D_Instr[25:0], 2'b00};
            end
            NPC_JR: begin
                redirect = 1'b1;
                target   = D_rs_val;
            end
            default: begin
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with F/D pipeline register: handshaked IMEM,
// one-entry stall buffer and delay-slot-aware redirect handling.
module fetch_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] D_rs_val,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic        D_valid
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  buf_instr, buf_instr_n;
    logic [31:0]  buf_pc, buf_pc_n;
    logic         pend_vld, pend_vld_n;
    logic [31:0]  pend_tgt, pend_tgt_n;
    logic [31:0]  d_instr_n, d_pc_n;
    logic         d_valid_n;
    logic         redirect;
    logic [31:0]  target;
    logic         take;

    npc_calc u_npc_calc (
        .D_Instr  (D_Instr),
        .D_PC     (D_PC),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .D_rs_val (D_rs_val),
        .redirect (redirect),
        .target   (target)
    );

    // Reset gates the request combinationally so an in-flight fetch drops at once.
    assign im_req  = reset && (state == S_REQ);
    assign im_addr = pc;
    assign take    = D_valid && !stall && redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_REQ;
            pc        <= PC_RESET;
            buf_instr <= NOP;
            buf_pc    <= 32'd0;
            pend_vld  <= 1'b0;
            pend_tgt  <= 32'd0;
            D_Instr   <= NOP;
            D_PC      <= 32'd0;
            D_valid   <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
            pend_vld  <= pend_vld_n;
            pend_tgt  <= pend_tgt_n;
            D_Instr   <= d_instr_n;
            D_PC      <= d_pc_n;
            D_valid   <= d_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
        pend_vld_n  = pend_vld;
        pend_tgt_n  = pend_tgt;
        d_instr_n   = D_Instr;
        d_pc_n      = D_PC;
        d_valid_n   = D_valid;
        case (state)
            S_REQ: begin
                if (im_ack) begin
                    // A redirect seen together with the slot's ack overrides sequential PC.
                    if (take)          pc_n = target;
                    else if (pend_vld) pc_n = pend_tgt;
                    else               pc_n = pc + 32'd4;
                    pend_vld_n = 1'b0;
                    if (!stall) begin
                        d_instr_n = im_rdata;
                        d_pc_n    = pc;
                        d_valid_n = 1'b1;
                    end else begin
                        buf_instr_n = im_rdata;
                        buf_pc_n    = pc;
                        state_n     = S_HOLD;
                    end
                end else begin
                    // Delay slot still in flight: park the target until it lands.
                    if (take) begin
                        pend_vld_n = 1'b1;
                        pend_tgt_n = target;
                    end
                    if (!stall) begin
                        d_instr_n = NOP;
                        d_pc_n    = pc;
                        d_valid_n = 1'b0;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    d_instr_n = buf_instr;
                    d_pc_n    = buf_pc;
                    d_valid_n = 1'b1;
                    state_n   = S_REQ;
                    if (take) pc_n = target;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model tracks the expected
// PC, F/D contents and stall buffer; outputs are compared every cycle.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  npc_sel = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] D_rs_val = 32'd0;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack = 1'b0;
    logic [31:0] im_rdata = 32'd0;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic        D_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_d_instr;
    logic [31:0] m_d_pc;
    logic        m_d_valid;
    logic [31:0] m_buf_instr_q[$];
    logic [31:0] m_buf_pc_q[$];
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] prog_head = 32'h2400_3000;

    fetch_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .D_rs_val (D_rs_val),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_ack   (im_ack),
        .im_rdata (im_rdata),
        .D_Instr  (D_Instr),
        .D_PC     (D_PC),
        .D_valid  (D_valid)
    );

    always #5 clk = ~clk;

    // Program image: the word at 0x3000 is chosen per scenario, the rest are tagged fillers.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_3000) return prog_head;
        return {16'h2400, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0000_3000;
        m_d_instr = 32'd0;
        m_d_pc    = 32'd0;
        m_d_valid = 1'b0;
        m_buf_instr_q.delete();
        m_buf_pc_q.delete();
        m_pend     = 1'b0;
        m_pend_tgt = 32'd0;
    endtask

    task automatic check_output();
        logic exp_req;
        exp_req = reset && (m_buf_instr_q.size() == 0);
        check("im_req", {31'd0, im_req}, {31'd0, exp_req});
        if (exp_req) check("im_addr", im_addr, m_pc);
        check("D_valid", {31'd0, D_valid}, {31'd0, m_d_valid});
        check("D_PC", D_PC, m_d_pc);
        check("D_Instr", D_Instr, m_d_instr);
    endtask

    // One clock of stimulus: drive inputs, advance the model, compare after the edge.
    task automatic apply_stimulus(input logic st, input logic ack, input logic [1:0] sel,
                                  input logic bt, input logic [31:0] rs);
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] word;
        logic [31:0] slot_pc;
        int          off;
        stall    = st;
        im_ack   = ack;
        npc_sel  = sel;
        br_taken = bt;
        D_rs_val = rs;
        word     = word_at(m_pc);
        im_rdata = ack ? word : 32'hDEAD_BEEF;

        slot_pc = m_d_pc + 32'd4;
        off     = int'($signed(m_d_instr[15:0]));
        redir   = m_d_valid && !st && (sel == 2'd2 || sel == 2'd3 || (sel == 2'd1 && bt));
        if (sel == 2'd1)      tgt = slot_pc + 32'(off * 4);
        else if (sel == 2'd2) tgt = (slot_pc & 32'hF000_0000) | ((m_d_instr & 32'h03FF_FFFF) * 4);
        else                  tgt = rs;

        if (m_buf_instr_q.size() == 0) begin
            if (ack) begin
                if (!st) begin
                    m_d_instr = word;
                    m_d_pc    = m_pc;
                    m_d_valid = 1'b1;
                end else begin
                    m_buf_instr_q.push_back(word);
                    m_buf_pc_q.push_back(m_pc);
                end
                m_pc   = redir ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
                m_pend = 1'b0;
            end else begin
                if (redir) begin
                    m_pend     = 1'b1;
                    m_pend_tgt = tgt;
                end
                if (!st) begin
                    m_d_instr = 32'd0;
                    m_d_pc    = m_pc;
                    m_d_valid = 1'b0;
                end
            end
        end else if (!st) begin
            m_d_instr = m_buf_instr_q.pop_front();
            m_d_pc    = m_buf_pc_q.pop_front();
            m_d_valid = 1'b1;
            if (redir) m_pc = tgt;
        end

        @(posedge clk);
        @(negedge clk);
        check_output();
    endtask

    task automatic do_reset(input logic [31:0] head);
        reset     = 1'b0;
        prog_head = head;
        stall     = 1'b0;
        im_ack    = 1'b0;
        npc_sel   = 2'b00;
        model_reset();
        #1 check_output();
        @(negedge clk);
        check_output();
        reset = 1'b1;
        #1 check_output();
    endtask

    initial begin
        // Reset, then zero-wait sequential fetch.
        do_reset(32'h2400_3000);
        check("lit_reset_req", {31'd0, im_req}, 32'd1);
        check("lit_first_addr", im_addr, 32'h0000_3000);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_seq_addr1", im_addr, 32'h0000_3004);
        check("lit_seq_dpc0", D_PC, 32'h0000_3000);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_seq_addr2", im_addr, 32'h0000_3008);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_seq_dpc2", D_PC, 32'h0000_3008);

        // Two memory wait cycles at 0x3004.
        do_reset(32'h2400_3000);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 0, 2'b00, 0, 0);
            check("lit_wait_addr", im_addr, 32'h0000_3004);
            check("lit_wait_bubble", {31'd0, D_valid}, 32'd0);
            check("lit_wait_nop", D_Instr, 32'd0);
        end
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_wait_dpc", D_PC, 32'h0000_3004);

        // Stall while the ack arrives: buffer, hold, release.
        do_reset(32'h2400_3000);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, 2'b00, 0, 0);
            check("lit_hold_req", {31'd0, im_req}, 32'd0);
            check("lit_hold_dpc", D_PC, 32'h0000_3000);
        end
        apply_stimulus(0, 0, 2'b00, 0, 0);
        check("lit_release_dpc", D_PC, 32'h0000_3004);
        check("lit_release_addr", im_addr, 32'h0000_3008);
        apply_stimulus(0, 1, 2'b00, 0, 0);

        // Taken beq (imm=4), zero-wait: slot then 0x3014.
        do_reset(32'h1000_0004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 1, 2'b01, 1, 0);
        check("lit_beq_tgt", im_addr, 32'h0000_3014);
        check("lit_beq_slot", D_PC, 32'h0000_3004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_beq_dpc", D_PC, 32'h0000_3014);

        // Not-taken beq stays sequential.
        do_reset(32'h1000_0004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 1, 2'b01, 0, 0);
        check("lit_bnt_addr", im_addr, 32'h0000_3008);

        // Backward branch (imm=-4) crosses below the reset PC.
        do_reset(32'h1000_FFFC);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 1, 2'b01, 1, 0);
        check("lit_bneg_addr", im_addr, 32'h0000_2FF4);
        apply_stimulus(0, 1, 2'b00, 0, 0);

        // Redirect resolved while the slot sits in the stall buffer.
        do_reset(32'h1000_0004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(1, 1, 2'b01, 1, 0);
        apply_stimulus(0, 0, 2'b01, 1, 0);
        check("lit_holdbr_addr", im_addr, 32'h0000_3014);
        check("lit_holdbr_slot", D_PC, 32'h0000_3004);
        apply_stimulus(0, 1, 2'b00, 0, 0);

        // j to index 0xC40 -> 0x3100.
        do_reset(32'h0800_0C40);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 1, 2'b10, 0, 0);
        check("lit_j_addr", im_addr, 32'h0000_3100);
        apply_stimulus(0, 1, 2'b00, 0, 0);

        // jr with the delay slot's ack delayed two cycles.
        do_reset(32'h03E0_0008);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 0, 2'b11, 0, 32'h0000_3100);
        check("lit_jr_hold1", im_addr, 32'h0000_3004);
        apply_stimulus(0, 0, 2'b00, 0, 0);
        check("lit_jr_hold2", im_addr, 32'h0000_3004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_jr_tgt", im_addr, 32'h0000_3100);
        check("lit_jr_slot", D_PC, 32'h0000_3004);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        check("lit_jr_dpc", D_PC, 32'h0000_3100);

        // Reset asserted during a waiting request.
        do_reset(32'h2400_3000);
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 0, 2'b00, 0, 0);
        reset = 1'b0;
        im_ack = 1'b1;
        model_reset();
        #1;
        check("lit_rst_req", {31'd0, im_req}, 32'd0);
        check("lit_rst_valid", {31'd0, D_valid}, 32'd0);
        check("lit_rst_dpc", D_PC, 32'd0);
        check("lit_rst_instr", D_Instr, 32'd0);
        check_output();
        @(negedge clk);
        reset  = 1'b1;
        im_ack = 1'b0;
        #1;
        check("lit_rel_addr", im_addr, 32'h0000_3000);
        check_output();
        apply_stimulus(0, 1, 2'b00, 0, 0);
        apply_stimulus(0, 1, 2'b00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
